nvdla_cacc_pwr_ctrl: RTL

NVDLA_CACC_PWR_CTRL -- requirements
Module: nvdla_cacc_pwr_ctrl

---
 rtl/nvdla_cacc_pwr_pkg.sv | 29 ++
 rtl/nvdla_cacc_pwr_cnt.sv | 28 ++
 rtl/nvdla_cacc_pwr_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/nvdla_cacc_pwr_pkg.sv
// Shared types and constants for the CACC power-control slice.
package nvdla_cacc_pwr_pkg;

    localparam int unsigned PWR_STATE_W = 3;
    localparam int unsigned IDLE_CNT_W  = 8;
    localparam int unsigned WAKE_CNT_W  = 4;
    localparam int unsigned DENY_CNT_W  = 8;

    localparam logic [PWR_STATE_W-1:0] PWR_RUN     = 3'd0;
    localparam logic [PWR_STATE_W-1:0] PWR_REQ     = 3'd1;
    localparam logic [PWR_STATE_W-1:0] PWR_DENY    = 3'd2;
    localparam logic [PWR_STATE_W-1:0] PWR_STOP    = 3'd3;
    localparam logic [PWR_STATE_W-1:0] PWR_GATED   = 3'd4;
    localparam logic [PWR_STATE_W-1:0] PWR_WAKE    = 3'd5;
    localparam logic [PWR_STATE_W-1:0] PWR_RESTORE = 3'd6;
    localparam logic [PWR_STATE_W-1:0] PWR_EXIT    = 3'd7;

    typedef enum logic [PWR_STATE_W-1:0] {
        ST_RUN     = PWR_RUN,
        ST_REQ     = PWR_REQ,
        ST_DENY    = PWR_DENY,
        ST_STOP    = PWR_STOP,
        ST_GATED   = PWR_GATED,
        ST_WAKE    = PWR_WAKE,
        ST_RESTORE = PWR_RESTORE,
        ST_EXIT    = PWR_EXIT
    } pwr_state_e;

endpackage

// File: rtl/nvdla_cacc_pwr_cnt.sv
// Loadable saturating up-counter; clear has priority over load, load over enable.
module nvdla_cacc_pwr_cnt
    import nvdla_cacc_pwr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/nvdla_cacc_pwr_ctrl.sv
// CACC power controller: Q-channel handshake, isolation/power-switch sequencing
// and retention restore. All outputs decode from the registered state.
module nvdla_cacc_pwr_ctrl
    import nvdla_cacc_pwr_pkg::*;
(
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       sw_pwr_down_req,
    input  logic       wake_req,
    input  logic       cacc_idle,
    input  logic [7:0] cfg_idle_thresh,
    input  logic [3:0] cfg_wake_dly,
    input  logic       qacceptn,
    input  logic       qdeny,
    output logic       qreqn,
    output logic       pr_restore,
    output logic       pwr_iso_en,
    output logic       pwr_gate_en,
    output logic [2:0] pwr_state,
    output logic [7:0] deny_cnt
);

    pwr_state_e              state_q;
    pwr_state_e              state_d;
    logic                    holdoff_q;
    logic [DENY_CNT_W-1:0]   deny_q;
    logic [IDLE_CNT_W-1:0]   idle_cnt;
    logic [WAKE_CNT_W-1:0]   wake_cnt;
    logic                    auto_trig;
    logic                    pd_req;
    logic                    gated_exit;
    logic                    wake_done;
    logic                    deny_evt;

    nvdla_cacc_pwr_cnt #(.WIDTH(IDLE_CNT_W)) u_idle_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .clr             ((state_q != ST_RUN) || !cacc_idle),
        .ld              (1'b0),
        .ld_val          ('0),
        .en              ((state_q == ST_RUN) && cacc_idle),
        .cnt             (idle_cnt)
    );

    // Loaded with 1 on GATED exit so the first WAKE cycle already counts;
    // a zero delay therefore still spends one cycle in WAKE.
    nvdla_cacc_pwr_cnt #(.WIDTH(WAKE_CNT_W)) u_wake_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .clr             ((state_q != ST_GATED) && (state_q != ST_WAKE)),
        .ld              ((state_q == ST_GATED) && gated_exit),
        .ld_val          (WAKE_CNT_W'(1)),
        .en              (state_q == ST_WAKE),
        .cnt             (wake_cnt)
    );

    assign auto_trig  = (cfg_idle_thresh != '0) && (idle_cnt >= cfg_idle_thresh);
    assign pd_req     = (sw_pwr_down_req || auto_trig) && qacceptn && !qdeny && !holdoff_q;
    assign gated_exit = wake_req || !sw_pwr_down_req;
    assign wake_done  = (wake_cnt >= cfg_wake_dly);
    assign deny_evt   = (state_q == ST_REQ) && qacceptn && qdeny;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (pd_req) state_d = ST_REQ;
            ST_REQ: begin
                if (!qacceptn && !qdeny) begin
                    state_d = ST_STOP;
                end else if (qacceptn && qdeny) begin
                    state_d = ST_DENY;
                end
            end
            ST_DENY:    if (qacceptn && !qdeny) state_d = ST_RUN;
            ST_STOP:    state_d = ST_GATED;
            ST_GATED:   if (gated_exit) state_d = ST_WAKE;
            ST_WAKE:    if (wake_done) state_d = ST_RESTORE;
            ST_RESTORE: state_d = ST_EXIT;
            ST_EXIT:    if (qacceptn) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q   <= ST_RUN;
            holdoff_q <= 1'b0;
            deny_q    <= '0;
        end else begin
            state_q   <= state_d;
            holdoff_q <= (state_q == ST_DENY) && (state_d == ST_RUN);
            if (deny_evt && (deny_q != '1)) begin
                deny_q <= deny_q + DENY_CNT_W'(1);
            end
        end
    end

    always_comb begin
        qreqn       = 1'b1;
        pr_restore  = 1'b0;
        pwr_iso_en  = 1'b0;
        pwr_gate_en = 1'b0;
        case (state_q)
            ST_REQ:     qreqn = 1'b0;
            ST_STOP: begin
                qreqn      = 1'b0;
                pwr_iso_en = 1'b1;
            end
            ST_GATED: begin
                qreqn       = 1'b0;
                pwr_iso_en  = 1'b1;
                pwr_gate_en = 1'b1;
            end
            ST_WAKE: begin
                qreqn      = 1'b0;
                pwr_iso_en = 1'b1;
            end
            ST_RESTORE: begin
                qreqn      = 1'b0;
                pr_restore = 1'b1;
            end
            default: ;
        endcase
    end

    assign pwr_state = state_q;
    assign deny_cnt  = deny_q;

endmodule
